// File: rtl/qpsk_demod_if.sv
// Sample/sync input bus and dibit/serial output bus of the QPSK demodulator.
// master drives samples and receives decisions; slave is the demodulator side.
interface qpsk_demod_if #(
    parameter int DATA_W = 16
);
    logic                     s_valid;
    logic signed [DATA_W-1:0] s_data;
    logic                     pulse;
    logic [1:0]               dibit;
    logic                     dibit_valid;
    logic                     dout;
    logic                     dout_valid;

    modport master (
        output s_valid, s_data, pulse,
        input  dibit, dibit_valid, dout, dout_valid
    );

    modport slave (
        input  s_valid, s_data, pulse,
        output dibit, dibit_valid, dout, dout_valid
    );
endinterface

// File: rtl/qpsk_demod.sv
// Coherent QPSK demodulator: 8-point cos/sin mix, integrate-and-dump, sign slicer, 2-bit serializer.
// Define QPSK_DEMOD_SOFT_EN to expose the dumped accumulators as soft_i/soft_q.
module qpsk_demod #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 8,
    parameter int ACC_W  = DATA_W + COEF_W + 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef QPSK_DEMOD_SOFT_EN
    output logic signed [ACC_W-1:0] soft_i,
    output logic signed [ACC_W-1:0] soft_q,
`endif
    qpsk_demod_if.slave             bus
);
    localparam int PROD_W = DATA_W + COEF_W;

    function automatic logic signed [COEF_W-1:0] cos_coef(input logic [2:0] k);
        unique case (k)
            3'd0:    return COEF_W'(127);
            3'd1:    return COEF_W'(90);
            3'd2:    return COEF_W'(0);
            3'd3:    return COEF_W'(-90);
            3'd4:    return COEF_W'(-127);
            3'd5:    return COEF_W'(-90);
            3'd6:    return COEF_W'(0);
            default: return COEF_W'(90);
        endcase
    endfunction

    function automatic logic signed [COEF_W-1:0] sin_coef(input logic [2:0] k);
        unique case (k)
            3'd0:    return COEF_W'(0);
            3'd1:    return COEF_W'(90);
            3'd2:    return COEF_W'(127);
            3'd3:    return COEF_W'(90);
            3'd4:    return COEF_W'(0);
            3'd5:    return COEF_W'(-90);
            3'd6:    return COEF_W'(-127);
            default: return COEF_W'(-90);
        endcase
    endfunction

    function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    // Zero slices as positive, so the decision is just the sign bit.
    function automatic logic slice_neg(input logic signed [ACC_W-1:0] a);
        return a[ACC_W-1];
    endfunction

    logic [2:0]               phase_p0;
    logic signed [ACC_W-1:0]  acc_i_p0;
    logic signed [ACC_W-1:0]  acc_q_p0;
    logic [1:0]               dibit_p1;
    logic                     vld_p1;
    logic                     dout_p1;
    logic                     dout_vld_p1;
    logic                     b0_pend_p1;
    logic                     b0_p1;
`ifdef QPSK_DEMOD_SOFT_EN
    logic signed [ACC_W-1:0]  soft_i_p1;
    logic signed [ACC_W-1:0]  soft_q_p1;
`endif

    logic [2:0]               phase_eff;
    logic signed [COEF_W-1:0] c_cos;
    logic signed [COEF_W-1:0] c_sin;
    logic signed [PROD_W-1:0] prod_i;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [ACC_W-1:0]  sum_i;
    logic signed [ACC_W-1:0]  sum_q;
    logic                     dump;

    // Mixer: a pulse forces the current sample onto phase 0.
    assign phase_eff = bus.pulse ? 3'd0 : phase_p0;
    assign c_cos     = cos_coef(phase_eff);
    assign c_sin     = sin_coef(phase_eff);
    assign prod_i    = PROD_W'(bus.s_data) * PROD_W'(c_cos);
    assign prod_q    = PROD_W'(bus.s_data) * PROD_W'(c_sin);
    assign sum_i     = acc_i_p0 + sext_prod(prod_i);
    assign sum_q     = acc_q_p0 + sext_prod(prod_q);
    assign dump      = bus.s_valid && !bus.pulse && (phase_p0 == 3'd7);

    // Stage p0: phase counter and integrators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_p0 <= 3'd0;
            acc_i_p0 <= '0;
            acc_q_p0 <= '0;
        end else if (bus.pulse) begin
            phase_p0 <= bus.s_valid ? 3'd1 : 3'd0;
            acc_i_p0 <= bus.s_valid ? sext_prod(prod_i) : '0;
            acc_q_p0 <= bus.s_valid ? sext_prod(prod_q) : '0;
        end else if (bus.s_valid) begin
            phase_p0 <= phase_p0 + 3'd1;
            acc_i_p0 <= dump ? '0 : sum_i;
            acc_q_p0 <= dump ? '0 : sum_q;
        end
    end

    // Stage p1: decision register and serializer; b0 follows b1 one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dibit_p1    <= 2'b00;
            vld_p1      <= 1'b0;
            dout_p1     <= 1'b0;
            dout_vld_p1 <= 1'b0;
            b0_pend_p1  <= 1'b0;
            b0_p1       <= 1'b0;
`ifdef QPSK_DEMOD_SOFT_EN
            soft_i_p1   <= '0;
            soft_q_p1   <= '0;
`endif
        end else begin
            vld_p1 <= dump;
            if (dump) begin
                dibit_p1    <= {slice_neg(sum_i), slice_neg(sum_q)};
                dout_p1     <= slice_neg(sum_i);
                dout_vld_p1 <= 1'b1;
                b0_pend_p1  <= 1'b1;
                b0_p1       <= slice_neg(sum_q);
`ifdef QPSK_DEMOD_SOFT_EN
                soft_i_p1   <= sum_i;
                soft_q_p1   <= sum_q;
`endif
            end else if (b0_pend_p1) begin
                dout_p1     <= b0_p1;
                dout_vld_p1 <= 1'b1;
                b0_pend_p1  <= 1'b0;
            end else begin
                dout_vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.dibit       = dibit_p1;
    assign bus.dibit_valid = vld_p1;
    assign bus.dout        = dout_p1;
    assign bus.dout_valid  = dout_vld_p1;
`ifdef QPSK_DEMOD_SOFT_EN
    assign soft_i          = soft_i_p1;
    assign soft_q          = soft_q_p1;
`endif
endmodule

// File: tb/tb_qpsk_demod.sv
// Directed bench for qpsk_demod: a sample-list model of integrate-and-dump checked every cycle,
// plus literal expectations for mapping, serial order, gaps, resync, full scale and reset.
module tb_qpsk_demod;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 27;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    qpsk_demod_if #(.DATA_W(DATA_W)) bus ();
`ifdef QPSK_DEMOD_SOFT_EN
    logic signed [ACC_W-1:0] soft_i;
    logic signed [ACC_W-1:0] soft_q;
`endif

    qpsk_demod #(.DATA_W(DATA_W), .COEF_W(8), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef QPSK_DEMOD_SOFT_EN
        .soft_i(soft_i),
        .soft_q(soft_q),
`endif
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int cos_t[8] = '{127, 90, 0, -90, -127, -90, 0, 90};
    int sin_t[8] = '{0, 90, 127, 90, 0, -90, -127, -90};

    // Model: samples of the current symbol kept as a list; decisions as a queue of output bits.
    int       mbuf[$];
    bit       mq[$];
    logic [1:0] e_dibit = 2'b00;
    bit       e_dv  = 1'b0;
    bit       e_ov  = 1'b0;
    bit       e_out = 1'b0;
    longint   e_si  = 0;
    longint   e_sq  = 0;
    longint   si, sq;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mbuf.delete();
            mq.delete();
            e_dibit = 2'b00; e_dv = 1'b0; e_ov = 1'b0; e_out = 1'b0; e_si = 0; e_sq = 0;
        end else begin
            e_dv = 1'b0;
            if (bus.pulse) begin
                mbuf.delete();
                if (bus.s_valid) mbuf.push_back(int'(bus.s_data));
            end else if (bus.s_valid) begin
                mbuf.push_back(int'(bus.s_data));
                if (mbuf.size() == 8) begin
                    si = 0; sq = 0;
                    for (int k = 0; k < 8; k++) begin
                        si += longint'(mbuf[k]) * cos_t[k];
                        sq += longint'(mbuf[k]) * sin_t[k];
                    end
                    e_dibit = {si < 0, sq < 0};
                    e_si = si; e_sq = sq; e_dv = 1'b1;
                    mq.push_back(si < 0);
                    mq.push_back(sq < 0);
                    mbuf.delete();
                end
            end
            if (mq.size() > 0) begin
                e_out = mq.pop_front();
                e_ov  = 1'b1;
            end else begin
                e_ov  = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, $signed(act), $signed(exp), $time);
        end
    endtask

    int dv_count = 0;
    int dv_cyc   = 0;
    bit dq[$];

    always @(negedge clk) begin
        chk("dibit_valid", bus.dibit_valid, e_dv);
        chk("dibit", bus.dibit, e_dibit);
        chk("dout_valid", bus.dout_valid, e_ov);
        if (e_ov) chk("dout", bus.dout, e_out);
`ifdef QPSK_DEMOD_SOFT_EN
        chk("soft_i", soft_i, e_si);
        chk("soft_q", soft_q, e_sq);
`endif
        if (bus.dibit_valid === 1'b1) begin
            dv_count++;
            dv_cyc = cyc;
        end
        if (bus.dout_valid === 1'b1) dq.push_back(bus.dout);
    end

    int pat[8];

    // sel: 0 amp*COS, 1 amp*SIN, 2 constant amp, 3 amp*sign(COS)
    task automatic set_pat(input int sel, input int amp);
        for (int k = 0; k < 8; k++) begin
            case (sel)
                0:       pat[k] = amp * cos_t[k];
                1:       pat[k] = amp * sin_t[k];
                2:       pat[k] = amp;
                default: pat[k] = (cos_t[k] > 0) ? amp : ((cos_t[k] < 0) ? -amp : 0);
            endcase
        end
    endtask

    task automatic drive(input bit v, input int d, input bit p);
        bus.s_valid = v;
        bus.s_data  = 16'(d);
        bus.pulse   = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 1'b0);
    endtask

    task automatic send(input int n, input int gap, input bit pls);
        for (int k = 0; k < n; k++) begin
            drive(1'b1, pat[k], pls && (k == 0));
            if (k < n - 1) repeat (gap) drive(1'b0, 0, 1'b0);
        end
        bus.s_valid = 1'b0;
        bus.pulse   = 1'b0;
    endtask

    task automatic chk_sym(input string name, input logic [1:0] d, input longint ei, input longint eq);
        chk({name, " strobe"}, bus.dibit_valid, 1'b1);
        chk({name, " dibit"}, bus.dibit, d);
`ifdef QPSK_DEMOD_SOFT_EN
        chk({name, " soft_i"}, soft_i, ei);
        chk({name, " soft_q"}, soft_q, eq);
`else
        if (ei != eq) tests = tests + 0;
`endif
    endtask

    int n0, st;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.s_valid = 1'b0; bus.s_data = '0; bus.pulse = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset dibit", bus.dibit, 2'b00);
        chk("reset dibit_valid", bus.dibit_valid, 1'b0);
        chk("reset dout", bus.dout, 1'b0);
        chk("reset dout_valid", bus.dout_valid, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Mapping of the four reference symbols
        set_pat(0, 100);  send(8, 0, 1'b1); chk_sym("T2 +cos", 2'b00, 6465800, 0);        idle(2);
        set_pat(0, -100); send(8, 0, 1'b1); chk_sym("T2 -cos", 2'b10, -6465800, 0);       idle(2);
        set_pat(1, 100);  send(8, 0, 1'b1); chk_sym("T2 +sin", 2'b00, 0, 6465800);        idle(2);
        set_pat(1, -100); send(8, 0, 1'b1); chk_sym("T2 -sin", 2'b01, 0, -6465800);       idle(2);

        // Serial order across two back-to-back symbols
        dq.delete();
        set_pat(0, -100); send(8, 0, 1'b1);
        set_pat(1, -100); send(8, 0, 1'b0);
        idle(3);
        chk("T3 bit count", dq.size(), 4);
        if (dq.size() >= 4) begin
            chk("T3 bit0", dq[0], 1'b1);
            chk("T3 bit1", dq[1], 1'b0);
            chk("T3 bit2", dq[2], 1'b0);
            chk("T3 bit3", dq[3], 1'b1);
        end

        // Latency without and with 3-cycle gaps
        set_pat(0, -100); st = cyc; send(8, 0, 1'b1);
        chk_sym("T4 nogap", 2'b10, -6465800, 0); idle(2);
        chk("T4 nogap latency", dv_cyc - st, 8);
        set_pat(0, -100); st = cyc; send(8, 3, 1'b1);
        chk_sym("T4 gap", 2'b10, -6465800, 0); idle(2);
        chk("T4 gap latency", dv_cyc - st, 8 + 7 * 3);

        // Resync on the 5th sample
        n0 = dv_count;
        set_pat(0, 100);  send(4, 0, 1'b1);
        set_pat(0, -100); send(8, 0, 1'b1);
        chk_sym("T5 resync", 2'b10, -6465800, 0); idle(2);
        chk("T5 strobes", dv_count - n0, 1);

        // Pulse with no sample clears the partial symbol
        n0 = dv_count;
        set_pat(1, -100); send(3, 0, 1'b1);
        drive(1'b0, 0, 1'b1);
        set_pat(1, 100);  send(8, 0, 1'b0);
        chk_sym("pulse idle", 2'b00, 0, 6465800); idle(2);
        chk("pulse idle strobes", dv_count - n0, 1);

        // Pulse coinciding with the phase-7 sample suppresses the dump
        n0 = dv_count;
        set_pat(0, 100);  send(7, 0, 1'b1);
        set_pat(1, -100); send(8, 0, 1'b1);
        chk_sym("pulse ph7", 2'b01, 0, -6465800); idle(2);
        chk("pulse ph7 strobes", dv_count - n0, 1);

        // Full-scale inputs
        set_pat(2, -32768); send(8, 0, 1'b1); chk_sym("T6 -fs", 2'b00, 0, 0);          idle(2);
        set_pat(3, 32767);  send(8, 0, 1'b1); chk_sym("T6 +sgn", 2'b00, 20118938, 0);  idle(2);

        // Reset in the middle of a dump/b0 window
        set_pat(0, -100); send(8, 0, 1'b1);
        chk_sym("T1 pre", 2'b10, -6465800, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("T1 async dibit", bus.dibit, 2'b00);
        chk("T1 async dibit_valid", bus.dibit_valid, 1'b0);
        chk("T1 async dout", bus.dout, 1'b0);
        chk("T1 async dout_valid", bus.dout_valid, 1'b0);
`ifdef QPSK_DEMOD_SOFT_EN
        chk("T1 async soft_i", soft_i, 0);
`endif
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n0 = dv_count;
        set_pat(0, -100); send(7, 0, 1'b0);
        idle(1);
        chk("T1 no early dump", dv_count - n0, 0);
        drive(1'b1, pat[7], 1'b0);
        bus.s_valid = 1'b0;
        chk_sym("T1 post", 2'b10, -6465800, 0);
        idle(3);
        chk("T1 strobes", dv_count - n0, 1);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
